// File: rtl/flowing_led_scheduler.sv
// flowing_led_scheduler: steps one lit position across an LED bank in one of four patterns
module flowing_led_scheduler #(
  parameter int N_LED = 4,
  parameter int T_STEP = 5_000_000,
  parameter int T_ON = 1_250_000,
  parameter int CW = $clog2(T_STEP),
  parameter int PW = $clog2(N_LED)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] LED_out,
  output logic [PW-1:0]    pos,
  output logic             step,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [PW-1:0] PMAX = PW'(N_LED - 1);
  state_t state;
  logic [CW-1:0] count;
  logic [1:0] mode_q;
  logic dir_up, wrap, lit, up_eff;
  logic [PW-1:0] pos_next;
  logic [N_LED-1:0] led_next;
  assign busy = state != IDLE;
  assign step = state == RUN && wrap;
  // step boundary, duty window, next pattern position and LED decode
  always_comb begin
    wrap = count == CW'(T_STEP - 1);
    lit = 32'(count) < T_ON;
    up_eff = pos == '0 ? 1'b1 : pos == PMAX ? 1'b0 : dir_up;
    pos_next = mode_q == 2'b00 ? (pos == PMAX ? '0 : pos + 1'b1)
             : mode_q == 2'b01 ? (pos == '0 ? PMAX : pos - 1'b1)
             : mode_q == 2'b10 ? (up_eff ? pos + 1'b1 : pos - 1'b1)
             : '0;
    led_next = !lit ? '0 : mode_q == 2'b11 ? '1 : N_LED'(1) << pos;
  end
  // sequencer state, step counter, pattern position and registered LED drive
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      count <= '0;
      pos <= '0;
      dir_up <= 1'b1;
      mode_q <= 2'b00;
      LED_out <= '0;
    end else if (state == IDLE) begin
      LED_out <= '0;
      if (start && !stop) begin
        state <= RUN;
        mode_q <= mode;
        count <= '0;
        pos <= mode == 2'b01 ? PMAX : '0;
        dir_up <= 1'b1;
      end
    end else if (stop) begin
      state <= IDLE;
      count <= '0;
      pos <= '0;
      dir_up <= 1'b1;
      LED_out <= '0;
    end else begin
      state <= pause ? PAUSE : RUN;
      LED_out <= led_next;
      if (!pause) begin
        count <= wrap ? '0 : count + 1'b1;
        if (wrap) begin
          pos <= pos_next;
          dir_up <= up_eff;
        end
      end
    end
  end
endmodule

// File: doc/flowing_led_scheduler.md
# flowing_led_scheduler

Sequencer for a bank of LEDs. A step counter divides the clock into fixed-length steps. In each step one LED is selected by a position pointer and driven for the first `T_ON` cycles of the step. The pointer moves between steps according to a pattern mode latched at start. The block sits between the board clock/reset and the LED pins, and replaces per-LED free-running blink modules with one controller that owns timing and pattern order.

## Interface
- `N_LED`, default 4: number of LEDs; ≥2.
- `T_STEP`, default 5_000_000: cycles per step (100 ms at 50 MHz); ≥2.
- `T_ON`, default 1_250_000: on-cycles at the start of each step; 0..`T_STEP`.
- `CW`, default `$clog2(T_STEP)`: step counter width.
- `PW`, default `$clog2(N_LED)`: position width.

- `CLK` in 1: the only clock; rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle request; begins a sequence.
- `stop` in 1: single-cycle request; aborts to idle.
- `pause` in 1: level; freezes the sequence while high.
- `mode` in 2: pattern, sampled only on an accepted start.
  - 00: shift-left.
  - 01: shift-right.
  - 10: bounce.
  - 11: all-blink.
- `LED_out` out `N_LED`: LED drive, registered, 1 = on.
- `pos` out `PW`: current position, registered.
- `step` out 1: high during the last cycle of each step in RUN.
- `busy` out 1: high in RUN or PAUSE.

## Operation
- States: IDLE, RUN, PAUSE.
- Reset values: state=IDLE, `count`=0, `pos`=0, direction=up, latched mode=00, `LED_out`=0, `busy`=0, `step`=0.
- IDLE → RUN on `start`=1 and `stop`=0.
  - Latch `mode`.
  - Set `count`=0.
  - Set `pos`=`N_LED`-1 for mode 01; otherwise 0.
  - Set direction=up.
- RUN:
  - `count` increments each cycle; at `T_STEP`-1 it wraps to 0 and `pos` advances.
  - Mode 00: `pos` = (`pos`+1) mod `N_LED`.
  - Mode 01: `pos` = (`pos`-1) mod `N_LED`.
  - Mode 10: `pos` moves in the current direction; direction flips on reaching 0 or `N_LED`-1. For N=4 the order is 0,1,2,3,2,1,0,1,…; endpoints are not repeated.
  - Mode 11: `pos` stays 0.
- RUN → PAUSE when `pause`=1 and `stop`=0. `count`, `pos`, direction and `LED_out` all hold.
- PAUSE → RUN when `pause`=0. Counting resumes from the held `count` with no lost or extra cycle.
- RUN or PAUSE → IDLE on `stop`=1. Next cycle `LED_out`=0; `count` and `pos` are cleared to their reset values.
- Request priority:
  - `stop` beats `start` and `pause`.
  - `start` in RUN or PAUSE is ignored; the mode is not re-latched.
  - `pause` in IDLE is ignored.
  - `mode` changes outside an accepted start are ignored.
- LED decode, evaluated on RUN state and current `count`:
  - lit = (`count` < `T_ON`).
  - Modes 00/01/10: `LED_out` = one-hot(`pos`) if lit, else 0.
  - Mode 11: `LED_out` = all ones if lit, else 0.
  - In IDLE: `LED_out`=0.
- Duty corner cases:
  - `T_ON`=0: LEDs never lit.
  - `T_ON`≥`T_STEP`: the selected LED is lit for the whole step, and at step boundaries the lit LED changes with no dark gap.

## Timing
- `LED_out` is registered from the decode of the previous cycle's state, `pos` and `count`. It lags `count` by one cycle.
- Start latency:
  - `start` sampled at edge E0 gives state=RUN, `count`=0, `pos`=P0 after E0.
  - `LED_out` = one-hot(P0) after E1, if `T_ON`>0.
  - `busy`=1 after E0.
- LED pulse shape per step: exactly `T_ON` cycles high, then `T_STEP`-`T_ON` cycles low, shifted by one cycle relative to `count`.
- `step` is combinational: (state==RUN) && (`count`==`T_STEP`-1).
  - Exactly one cycle per step.
  - Never high in PAUSE or IDLE.
- `pos` updates at the same edge where `count` wraps to 0.
- Stop: `stop` sampled at edge E gives `busy`=0 after E and `LED_out`=0 after E; no trailing pulse.
- `RST` asserted at any time forces all state and outputs to their reset values immediately, independent of `CLK`. After release the block stays in IDLE until `start`.

## Test plan
Parameters for all scenarios: `N_LED`=4, `T_STEP`=8, `T_ON`=2.
- Reset then `start` with mode 00:
  - `LED_out` goes 0001 for 2 cycles, then 0000 for 6 cycles, then 0010, 0100, 1000, 0001.
  - `step` pulses every 8 cycles, coinciding with `count`=7.
  - First LED high one cycle after the start edge.
- Mode 10 for 8 steps: `pos` sequence is 0,1,2,3,2,1,0,1. Mode 01 from start: `pos` sequence is 3,2,1,0,3.
- Mode 11: every step `LED_out`=1111 for 2 cycles, then 0000 for 6; `pos` stays 0.
- Pause:
  - Assert `pause` for 5 cycles at `count`=3, step 1.
  - `count` and `LED_out` hold; `step` stays low.
  - After release the step completes after 4 more cycles; total elapsed time = 8+5 cycles.
- Request conflicts:
  - `start` and `stop` in the same cycle from IDLE: the block stays IDLE.
  - `start` with mode 01 during a mode-00 RUN: ignored, order unchanged.
  - `stop` in PAUSE: next cycle IDLE, `LED_out`=0, `busy`=0.
- Async reset mid-step (`count`=5, `pos`=2): `LED_out`, `pos`, `busy` and `step` go to 0 without a clock edge. After release the block stays idle; a new `start` restarts at `pos`=0.
